// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the keypad responder.
//   state_e   : responder FSM states
//   key_pos_t : (row, col) position of a key on the 4x4 matrix
//   KEY_MAP   : hex key code -> packed {row, col}
//   ROW_IDLE  : row value with no key closed (all returns high)
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_PRESS,
        ST_BOUNCE_OUT,
        ST_RELEASE
    } state_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
    } key_pos_t;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Indexed by key code; each entry is {row[1:0], col[1:0]}.
    // Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD,  // F -> (3,1)
        4'hE,  // E -> (3,2)
        4'hF,  // D -> (3,3)
        4'hB,  // C -> (2,3)
        4'h7,  // B -> (1,3)
        4'h3,  // A -> (0,3)
        4'hA,  // 9 -> (2,2)
        4'h9,  // 8 -> (2,1)
        4'h8,  // 7 -> (2,0)
        4'h6,  // 6 -> (1,2)
        4'h5,  // 5 -> (1,1)
        4'h4,  // 4 -> (1,0)
        4'h2,  // 3 -> (0,2)
        4'h1,  // 2 -> (0,1)
        4'h0,  // 1 -> (0,0)
        4'hC   // 0 -> (3,0)
    };

    function automatic key_pos_t key_pos(input logic [3:0] code);
        return key_pos_t'(KEY_MAP[code]);
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync -- 2-flop synchronizer for the scanner's column strobes.
//   clock   : system clock
//   reset_n : async active-low reset, flops reset to ROW_IDLE (all high)
//   async_i : column strobes from the scanner, asynchronous to clock
//   sync_o  : synchronized column strobes
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] async_i,
    output logic [3:0] sync_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= ROW_IDLE;
            sync_q <= ROW_IDLE;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_responder.sv
// keypad_responder -- emulates a 4x4 hex keypad towards a row/column scanner.
// A requested key is closed for HOLD_CYCLES, then released and held open for
// GAP_CYCLES before the next request is accepted.
//   clock, reset_n  : system clock, async active-low reset
//   col             : active-low column strobes (async), synchronized internally
//   row             : active-low row returns, registered
//   key_valid/code  : press request and hex key to press
//   key_ready, busy : ready only in IDLE; busy is its complement
//   press_count     : completed presses, modulo 256
// Build option: define KEYPAD_BOUNCE_EN to add contact bounce (8 toggles every
// BOUNCE_PERIOD cycles) on press and release. Hold/gap timing is unaffected.
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned GAP_CYCLES    = 50000,
    parameter int unsigned BOUNCE_PERIOD = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic [7:0] press_count
);

    if (BOUNCE_PERIOD == 0) begin : g_bad_bounce_period
        $error("BOUNCE_PERIOD must be non-zero");
    end

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  count_q, count_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_s;
    logic        closed_d;
    key_pos_t    pos;

`ifdef KEYPAD_BOUNCE_EN
    logic [31:0] bcnt_q, bcnt_d;
    logic [2:0]  bphase_q, bphase_d;
`endif

    keypad_col_sync u_col_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (col),
        .sync_o  (col_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        code_d  = code_q;
`ifdef KEYPAD_BOUNCE_EN
        bcnt_d   = bcnt_q;
        bphase_d = bphase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    code_d = key_code;
                    cnt_d  = '0;
`ifdef KEYPAD_BOUNCE_EN
                    state_d = ST_BOUNCE_IN;
`else
                    state_d = ST_PRESS;
`endif
                end
            end
            ST_PRESS: begin
                if (cnt_q == HOLD_CYCLES - 1) begin
                    cnt_d   = '0;
                    count_d = count_q + 8'd1;
`ifdef KEYPAD_BOUNCE_EN
                    state_d = ST_BOUNCE_OUT;
`else
                    state_d = ST_RELEASE;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            // Eight phases of BOUNCE_PERIOD cycles; the phase LSB selects the
            // contact. The phase counter wraps to 0 on the way out.
            ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
                if (bcnt_q == BOUNCE_PERIOD - 1) begin
                    bcnt_d   = '0;
                    bphase_d = bphase_q + 3'd1;
                    if (bphase_q == 3'd7) begin
                        state_d = (state_q == ST_BOUNCE_IN) ? ST_PRESS : ST_RELEASE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 32'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Contact state is taken from the next state so the registered row lines
    // up with the FSM state rather than lagging it by a cycle.
    always_comb begin
        closed_d = 1'b0;
        case (state_d)
            ST_PRESS:      closed_d = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            ST_BOUNCE_IN:  closed_d = ~bphase_d[0];
            ST_BOUNCE_OUT: closed_d = bphase_d[0];
`endif
            default:       closed_d = 1'b0;
        endcase
    end

    // Only the captured key's row can drop, and only while its own column is
    // strobed; other low columns have no effect.
    always_comb begin
        pos   = key_pos(code_d);
        row_d = ROW_IDLE;
        if (closed_d && !col_s[pos.c]) begin
            row_d[pos.r] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            code_q  <= '0;
            row_q   <= ROW_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            code_q  <= code_d;
            row_q   <= row_d;
        end
    end

`ifdef KEYPAD_BOUNCE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q   <= '0;
            bphase_q <= '0;
        end else begin
            bcnt_q   <= bcnt_d;
            bphase_q <= bphase_d;
        end
    end
`endif

    assign row         = row_q;
    assign key_ready   = (state_q == ST_IDLE);
    assign busy        = ~key_ready;
    assign press_count = count_q;

endmodule
